// File: rtl/alu_share_ctrl_pkg.sv
// Shared types for the ALU-sharing controller: opcodes, FSM states and default widths.
package alu_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int OP_W_DEF  = 3;
  localparam int RES_W_DEF = 5;
  localparam int CNT_W     = 3;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_ADD  = 3'd3,
    OP_LAND = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [7:0] op);
    return op <= 8'(OP_LAND);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on contention the one not served last wins.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_id_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_id_o = valid_i[1];
    if (valid_i == 2'b11) gnt_id_o = ~last_id_i;
    gnt_o = 2'b00;
    if (|valid_i) gnt_o = gnt_id_o ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: round-robin grant, operand latch,
// timed ALU enable and a requester-tagged valid/ready response.
//
// state | meaning
// IDLE  | waiting for a request; only here is the winner's ready driven
// ISSUE | alu_enable held with latched op/operands for ALU_LAT cycles
// RESP  | response held stable until rsp_ready
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             alu_enable,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [RES_W-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_err
);

  state_e             state_q, state_d;
  logic               last_id_q, last_id_d;
  logic               id_q, id_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic [1:0]         gnt;
  logic               gnt_id;
  logic [OP_W-1:0]    sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b;

  rr_arb2 u_arb (
    .valid_i   ({req1_valid, req0_valid}),
    .last_id_i (last_id_q),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id)
  );

  assign sel_op = gnt_id ? req1_op : req0_op;
  assign sel_a  = gnt_id ? req1_a  : req0_a;
  assign sel_b  = gnt_id ? req1_b  : req0_b;

  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    id_d       = id_q;
    lat_cnt_d  = lat_cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          op_d      = sel_op;
          a_d       = sel_a;
          b_d       = sel_b;
          id_d      = gnt_id;
          last_id_d = gnt_id;
          if (op_is_legal(8'(sel_op))) begin
            state_d   = ISSUE;
            lat_cnt_d = '0;
          end else begin
            // Illegal opcodes never reach the ALU.
            state_d    = RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            rsp_id_d   = gnt_id;
          end
        end
      end
      ISSUE: begin
        lat_cnt_d = lat_cnt_q + CNT_W'(1);
        if (lat_cnt_q == CNT_W'(ALU_LAT - 1)) begin
          rsp_data_d = alu_result;
          rsp_err_d  = 1'b0;
          rsp_id_d   = id_q;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_id_q  <= 1'b1;
      id_q       <= 1'b0;
      lat_cnt_q  <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_id_q  <= last_id_d;
      id_q       <= id_d;
      lat_cnt_q  <= lat_cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req0_ready = (state_q == IDLE) && rst_n && gnt[0];
  assign req1_ready = (state_q == IDLE) && rst_n && gnt[1];
  assign alu_enable = (state_q == ISSUE);
  assign alu_op     = alu_enable ? op_q : '0;
  assign alu_a      = alu_enable ? a_q  : '0;
  assign alu_b      = alu_enable ? b_q  : '0;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: three instances (ALU_LAT 1, 3, 4) share inputs,
// each driving its own stub ALU; every scenario checks one instance.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int W  = 4;
  localparam int OW = 3;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, rsp_ready;
  logic [OW-1:0] req0_op, req1_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;

  logic [2:0]    rdy0, rdy1, en, rv, rid, rerr;
  logic [OW-1:0] aop   [3];
  logic [W-1:0]  aa    [3];
  logic [W-1:0]  ab    [3];
  logic [RW-1:0] ares  [3];
  logic [RW-1:0] rdata [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] alu_stub(input logic [OW-1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {1'b0, a} + {1'b0, b};
      3'd4:    return {4'b0, (a != 4'h0) && (b != 4'h0)};
      default: return '0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    alu_share_ctrl #(.WIDTH(W), .OP_W(OW), .RES_W(RW), .ALU_LAT(LAT)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (rdy0[g]),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (rdy1[g]),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .alu_enable (en[g]),
      .alu_op     (aop[g]),
      .alu_a      (aa[g]),
      .alu_b      (ab[g]),
      .alu_result (ares[g]),
      .rsp_valid  (rv[g]),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rid[g]),
      .rsp_data   (rdata[g]),
      .rsp_err    (rerr[g])
    );
    assign ares[g] = alu_stub(aop[g], aa[g], ab[g]);
  end

  function automatic logic [21:0] outs(input int g);
    return {rdy0[g], rdy1[g], en[g], aop[g], aa[g], ab[g], rv[g], rid[g], rdata[g], rerr[g]};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    do_reset(); #1;
    checks++;
    if (outs(1) !== 22'h0) begin errors++; $display("FAIL reset_outs got %h exp %h", outs(1), 22'h0); end
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 4'h1; req0_b = 4'h2; #1;
    checks++;
    if (rdy0[1] !== 1'b1) begin errors++; $display("FAIL reset_first_accept got %b exp 1", rdy0[1]); end
    step(); req0_valid = 1'b0; step(); #1;
    checks++;
    if (en[1] !== 1'b1) begin errors++; $display("FAIL reset_issue_en got %b exp 1", en[1]); end
    rst_n = 1'b0;
    step(); rst_n = 1'b1; #1;
    checks++;
    if (outs(1) !== 22'h0) begin errors++; $display("FAIL reset_mid_issue got %h exp %h", outs(1), 22'h0); end
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 4'hC; req0_b = 4'hA; #1;
    checks++;
    if (rdy0[1] !== 1'b1) begin errors++; $display("FAIL reset_reaccept got %b exp 1", rdy0[1]); end
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      step(); req0_valid = 1'b0; #1;
      if (rv[1]) n = i;
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL reset_lat3_latency got %0d exp 4", n); end
    checks++;
    if ({rid[1], rdata[1], rerr[1]} !== {1'b0, 5'h08, 1'b0})
      begin errors++; $display("FAIL reset_lat3_rsp got %h exp %h", {rid[1], rdata[1], rerr[1]}, {1'b0, 5'h08, 1'b0}); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_and_lat1();
    do_reset();
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 4'hC; req0_b = 4'hA; #1;
    checks++;
    if ({rdy0[0], rdy1[0]} !== 2'b10) begin errors++; $display("FAIL and_ready got %b exp 10", {rdy0[0], rdy1[0]}); end
    step(); req0_valid = 1'b0; #1;
    checks++;
    if ({en[0], aop[0], aa[0], ab[0], rv[0]} !== {1'b1, 3'd0, 4'hC, 4'hA, 1'b0})
      begin errors++; $display("FAIL and_issue got %h exp %h", {en[0], aop[0], aa[0], ab[0], rv[0]}, {1'b1, 3'd0, 4'hC, 4'hA, 1'b0}); end
    step(); #1;
    checks++;
    if ({en[0], aa[0], ab[0], rv[0], rid[0], rdata[0], rerr[0]} !== {1'b0, 8'h00, 1'b1, 1'b0, 5'h08, 1'b0})
      begin errors++; $display("FAIL and_rsp got %h exp %h", {en[0], aa[0], ab[0], rv[0], rid[0], rdata[0], rerr[0]}, {1'b0, 8'h00, 1'b1, 1'b0, 5'h08, 1'b0}); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0; #1;
    checks++;
    if (rv[0] !== 1'b0) begin errors++; $display("FAIL and_rsp_drop got %b exp 0", rv[0]); end
  endtask

  task automatic test_round_robin();
    int ng, nr;
    logic       exp_id;
    logic [4:0] exp_d;
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD;  req0_a = 4'hF; req0_b = 4'h1;
    req1_valid = 1'b1; req1_op = OP_LAND; req1_a = 4'h0; req1_b = 4'h5;
    ng = 0; nr = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      #1;
      if (rdy0[0] | rdy1[0]) begin
        checks++;
        if ({rdy1[0], rdy0[0]} !== ((ng % 2 == 0) ? 2'b01 : 2'b10) || c != 3 * ng)
          begin errors++; $display("FAIL rr_grant got %b at cycle %0d exp %b at cycle %0d", {rdy1[0], rdy0[0]}, c, (ng % 2 == 0) ? 2'b01 : 2'b10, 3 * ng); end
        ng++;
      end
      if (rv[0]) begin
        exp_id = (nr % 2 == 1);
        exp_d  = exp_id ? 5'h00 : 5'h10;
        checks++;
        if ({rid[0], rdata[0], rerr[0]} !== {exp_id, exp_d, 1'b0} || c != 3 * nr + 2)
          begin errors++; $display("FAIL rr_rsp got %h at cycle %0d exp %h at cycle %0d", {rid[0], rdata[0], rerr[0]}, c, {exp_id, exp_d, 1'b0}, 3 * nr + 2); end
        nr++;
      end
    end
    checks++;
    if (ng !== 4 || nr !== 4) begin errors++; $display("FAIL rr_counts got %0d/%0d exp 4/4", ng, nr); end
    step(); req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_lat4_or();
    int n, ne;
    do_reset();
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 4'h3; req1_b = 4'h8; #1;
    checks++;
    if ({rdy1[2], rdy0[2]} !== 2'b10) begin errors++; $display("FAIL lat4_ready got %b exp 10", {rdy1[2], rdy0[2]}); end
    n = 0; ne = 0;
    for (int i = 1; i <= 12 && n == 0; i++) begin
      step(); req1_valid = 1'b0; #1;
      if (en[2]) begin
        ne++;
        checks++;
        if ({aop[2], aa[2], ab[2]} !== {3'd1, 4'h3, 4'h8})
          begin errors++; $display("FAIL lat4_operands got %h exp %h", {aop[2], aa[2], ab[2]}, {3'd1, 4'h3, 4'h8}); end
      end
      if (rv[2]) n = i;
    end
    checks++;
    if (ne !== 4) begin errors++; $display("FAIL lat4_enable_cycles got %0d exp 4", ne); end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL lat4_latency got %0d exp 5", n); end
    checks++;
    if ({rid[2], rdata[2], rerr[2]} !== {1'b1, 5'h0B, 1'b0})
      begin errors++; $display("FAIL lat4_rsp got %h exp %h", {rid[2], rdata[2], rerr[2]}, {1'b1, 5'h0B, 1'b0}); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1'b1; req0_op = OP_XOR; req0_a = 4'h5; req0_b = 4'h3; #1;
    checks++;
    if (rdy0[0] !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", rdy0[0]); end
    step(); req0_op = OP_AND; req0_a = 4'hF; req0_b = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      checks++;
      if ({rv[0], rid[0], rdata[0], rerr[0], rdy0[0]} !== {1'b1, 1'b0, 5'h06, 1'b0, 1'b0})
        begin errors++; $display("FAIL bp_hold got %h exp %h", {rv[0], rid[0], rdata[0], rerr[0], rdy0[0]}, {1'b1, 1'b0, 5'h06, 1'b0, 1'b0}); end
    end
    step(); rsp_ready = 1'b1; #1;
    checks++;
    if ({rv[0], rdy0[0]} !== 2'b10) begin errors++; $display("FAIL bp_handshake got %b exp 10", {rv[0], rdy0[0]}); end
    step(); rsp_ready = 1'b0; #1;
    checks++;
    if ({rv[0], rdy0[0]} !== 2'b01) begin errors++; $display("FAIL bp_next_accept got %b exp 01", {rv[0], rdy0[0]}); end
    step(); req0_valid = 1'b0; #1;
    checks++;
    if ({en[0], aop[0], aa[0], ab[0]} !== {1'b1, 3'd0, 4'hF, 4'hF})
      begin errors++; $display("FAIL bp_next_issue got %h exp %h", {en[0], aop[0], aa[0], ab[0]}, {1'b1, 3'd0, 4'hF, 4'hF}); end
    step(); rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    req0_valid = 1'b1; req0_op = 3'd6; req0_a = 4'h7; req0_b = 4'h7; #1;
    checks++;
    if ({rdy0[0], en[0]} !== 2'b10) begin errors++; $display("FAIL ill_accept got %b exp 10", {rdy0[0], en[0]}); end
    step(); req0_valid = 1'b0; #1;
    checks++;
    if ({en[0], aa[0], rv[0], rerr[0], rdata[0], rid[0]} !== {1'b0, 4'h0, 1'b1, 1'b1, 5'h00, 1'b0})
      begin errors++; $display("FAIL ill_rsp got %h exp %h", {en[0], aa[0], rv[0], rerr[0], rdata[0], rid[0]}, {1'b0, 4'h0, 1'b1, 1'b1, 5'h00, 1'b0}); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0; #1;
    checks++;
    if ({rv[0], en[0]} !== 2'b00) begin errors++; $display("FAIL ill_after got %b exp 00", {rv[0], en[0]}); end
    req1_valid = 1'b1; req1_op = 3'd7; req1_a = 4'h1; req1_b = 4'h1;
    step(); req1_valid = 1'b0; #1;
    checks++;
    if ({en[0], rv[0], rerr[0], rdata[0], rid[0]} !== {1'b0, 1'b1, 1'b1, 5'h00, 1'b1})
      begin errors++; $display("FAIL ill_rsp_req1 got %h exp %h", {en[0], rv[0], rerr[0], rdata[0], rid[0]}, {1'b0, 1'b1, 1'b1, 5'h00, 1'b1}); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_and_lat1();
    test_round_robin();
    test_lat4_or();
    test_backpressure();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
